// File: rtl/dcache_ctrl_if.sv
// CPU and memory side signals of the direct-mapped write-back data cache.
// The slave modport is the cache; the master modport is the pipeline/memory environment.
interface dcache_ctrl_if;
  logic        RdReq;
  logic        WrReq;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [3:0]  ByteEn;
  logic [31:0] RdData;
  logic        DCacheMiss;
  logic        MemRdReq;
  logic        MemWrReq;
  logic [31:0] MemAddr;
  logic [31:0] MemWrData;
  logic [31:0] MemRdData;
  logic        MemAck;

  modport slave (
    input  RdReq, WrReq, Addr, WrData, ByteEn, MemRdData, MemAck,
    output RdData, DCacheMiss, MemRdReq, MemWrReq, MemAddr, MemWrData
  );

  modport master (
    output RdReq, WrReq, Addr, WrData, ByteEn, MemRdData, MemAck,
    input  RdData, DCacheMiss, MemRdReq, MemWrReq, MemAddr, MemWrData
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller with zero-latency hits and
// word-serial write-back / refill against a simple ack-based memory port.
//
// state  | meaning
// IDLE   | serve hits; on miss pick WB (dirty victim) or REFILL
// WB     | write victim line to memory one word per MemAck
// REFILL | read requested line from memory one word per MemAck
module dcache_ctrl #(
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          CpuRst_n,
  dcache_ctrl_if.slave  bus
);

  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = 2 + WORD_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]    miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [SETS-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q [SETS];
  logic [TAG_W-1:0]    tag_d [SETS];
  logic [31:0]         data_q [SETS][LINE_WORDS];
  logic [31:0]         data_d [SETS][LINE_WORDS];

  logic [IDX_W-1:0]    req_idx;
  logic [WORD_W-1:0]   req_word;
  logic [TAG_W-1:0]    req_tag;
  logic                req;
  logic                hit;
  logic                last_word;
  logic                addr_unused;

  logic                mem_rd_req;
  logic                mem_wr_req;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wr_data;

  assign req_idx     = bus.Addr[2+WORD_W +: IDX_W];
  assign req_word    = bus.Addr[2 +: WORD_W];
  assign req_tag     = bus.Addr[TAG_LSB +: TAG_W];
  assign addr_unused = ^bus.Addr[1:0];

  assign req       = bus.RdReq | bus.WrReq;
  assign hit       = (state_q == IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_word = (cnt_q == WORD_W'(LINE_WORDS - 1));

  assign bus.DCacheMiss = req && !hit;
  assign bus.RdData     = data_q[req_idx][req_word];
  assign bus.MemRdReq   = mem_rd_req;
  assign bus.MemWrReq   = mem_wr_req;
  assign bus.MemAddr    = mem_addr;
  assign bus.MemWrData  = mem_wr_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_idx_d  = miss_idx_q;
    miss_tag_d  = miss_tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // a simultaneous RdReq/WrReq is a store
            if (bus.WrReq) begin
              for (int b = 0; b < 4; b++) begin
                if (bus.ByteEn[b]) begin
                  data_d[req_idx][req_word][8*b +: 8] = bus.WrData[8*b +: 8];
                end
              end
              dirty_d[req_idx] = 1'b1;
            end
          end else begin
            // line coordinates are captured so a dropped request still finishes the fill
            miss_idx_d = req_idx;
            miss_tag_d = req_tag;
            cnt_d      = '0;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_d = WB;
            end else begin
              state_d = REFILL;
            end
          end
        end
      end

      WB: begin
        mem_wr_req  = 1'b1;
        mem_addr    = {tag_q[miss_idx_q], miss_idx_q, cnt_q, 2'b00};
        mem_wr_data = data_q[miss_idx_q][cnt_q];
        if (bus.MemAck) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = REFILL;
          end else begin
            cnt_d = cnt_q + WORD_W'(1);
          end
        end
      end

      REFILL: begin
        mem_rd_req = 1'b1;
        mem_addr   = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
        if (bus.MemAck) begin
          data_d[miss_idx_q][cnt_q] = bus.MemRdData;
          if (last_word) begin
            cnt_d               = '0;
            valid_d[miss_idx_q] = 1'b1;
            dirty_d[miss_idx_q] = 1'b0;
            tag_d[miss_idx_q]   = miss_tag_q;
            state_d             = IDLE;
          end else begin
            cnt_d = cnt_q + WORD_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge CpuRst_n) begin
    if (!CpuRst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // tag and data storage is qualified by valid, so it carries no reset
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic checked against
// a line-level cache model and a separate memory image.
module tb_dcache_ctrl;
  localparam int SETS = 8;
  localparam int LW   = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk      = 1'b0;
  logic CpuRst_n = 1'b0;

  dcache_ctrl_if bus();

  dcache_ctrl #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk      (clk),
    .CpuRst_n (CpuRst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory seen by the DUT, and the model's own copy
  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // memory responder: acks after ack_delay wait cycles, logs every accepted word
  int   ack_delay = 0;
  txn_t log_q[$];

  initial begin
    int          wait_cnt = 0;
    bit          pend     = 0;
    logic [31:0] pend_addr = '0;
    logic        pend_we   = 1'b0;
    bus.MemAck    = 1'b0;
    bus.MemRdData = '0;
    forever begin
      @(negedge clk);
      if (!CpuRst_n) begin
        bus.MemAck = 1'b0;
        wait_cnt   = 0;
        pend       = 0;
      end else if (bus.MemRdReq || bus.MemWrReq) begin
        check("mem_excl", {31'b0, bus.MemRdReq & bus.MemWrReq}, 32'd0);
        if (pend) begin
          check("hold_addr", bus.MemAddr, pend_addr);
          check("hold_dir", {31'b0, bus.MemWrReq}, {31'b0, pend_we});
        end
        if (wait_cnt >= ack_delay) begin
          bus.MemAck    = 1'b1;
          bus.MemRdData = mem_rd(bus.MemAddr);
          if (bus.MemWrReq) begin
            mem[bus.MemAddr] = bus.MemWrData;
            log_q.push_back(txn_t'{we: 1'b1, addr: bus.MemAddr, data: bus.MemWrData});
          end else begin
            log_q.push_back(txn_t'{we: 1'b0, addr: bus.MemAddr, data: bus.MemRdData});
          end
          wait_cnt = 0;
          pend     = 0;
        end else begin
          bus.MemAck = 1'b0;
          wait_cnt++;
          pend      = 1;
          pend_addr = bus.MemAddr;
          pend_we   = bus.MemWrReq;
        end
      end else begin
        // stray acks while idle must be ignored by the cache
        bus.MemAck    = ($urandom_range(0, 3) == 0);
        bus.MemRdData = $urandom;
        wait_cnt      = 0;
        pend          = 0;
      end
    end
  end

  // line-level reference cache
  logic        ref_valid [SETS];
  logic        ref_dirty [SETS];
  int unsigned ref_tag   [SETS];
  logic [31:0] ref_line  [SETS][LW];
  txn_t        exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_req(input bit wr, input int unsigned addr, input logic [31:0] wd,
                           input logic [3:0] be, output bit hit, output logic [31:0] rd);
    int unsigned line = addr / (LW * 4);
    int unsigned idx  = line % SETS;
    int unsigned tag  = line / SETS;
    int unsigned w    = (addr / 4) % LW;
    int unsigned a;
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (!hit) begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        for (int i = 0; i < LW; i++) begin
          a = ((ref_tag[idx] * SETS + idx) * LW + i) * 4;
          ref_mem[a] = ref_line[idx][i];
          exp_q.push_back(txn_t'{we: 1'b1, addr: a, data: ref_line[idx][i]});
        end
      end
      for (int i = 0; i < LW; i++) begin
        a = (line * LW + i) * 4;
        ref_line[idx][i] = ref_rd(a);
        exp_q.push_back(txn_t'{we: 1'b0, addr: a, data: ref_line[idx][i]});
      end
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_tag[idx]   = tag;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_line[idx][w][8*b +: 8] = wd[8*b +: 8];
      end
      ref_dirty[idx] = 1'b1;
    end
    rd = ref_line[idx][w];
  endtask

  task automatic check_txns(input string tag);
    check({tag, "_ntxn"}, log_q.size(), exp_q.size());
    if (log_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        check({tag, "_we"},   {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
        check({tag, "_addr"}, log_q[i].addr, exp_q[i].addr);
        check({tag, "_data"}, log_q[i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int dly);
    bit          hit;
    logic [31:0] exp_rd;
    int          cyc;
    int          exp_cyc;
    log_q.delete();
    exp_q.delete();
    model_req(wr, addr, wd, be, hit, exp_rd);
    exp_cyc   = hit ? 0 : exp_q.size() * (dly + 1) + 1;
    ack_delay = dly;
    @(negedge clk);
    bus.RdReq  = rd;
    bus.WrReq  = wr;
    bus.Addr   = addr;
    bus.WrData = wd;
    bus.ByteEn = be;
    #1;
    cyc = 0;
    while (bus.DCacheMiss === 1'b1 && cyc < 400) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("miss_cycles", cyc, exp_cyc);
    if (rd && !wr) check("rdata", bus.RdData, exp_rd);
    check_txns("req");
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.RdReq = 1'b0;
    bus.WrReq = 1'b0;
  endtask

  initial begin
    bit          hit;
    logic [31:0] dummy;
    int          cyc;
    logic [31:0] a;

    bus.RdReq  = 1'b0;
    bus.WrReq  = 1'b0;
    bus.Addr   = '0;
    bus.WrData = '0;
    bus.ByteEn = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 4*i]     = 32'h11 * (i + 1);
      ref_mem[32'h100 + 4*i] = 32'h11 * (i + 1);
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_miss",    {31'b0, bus.DCacheMiss}, 32'd0);
    check("rst_memrd",   {31'b0, bus.MemRdReq},   32'd0);
    check("rst_memwr",   {31'b0, bus.MemWrReq},   32'd0);
    check("rst_memaddr", bus.MemAddr,             32'd0);
    check("rst_memwd",   bus.MemWrData,           32'd0);
    @(posedge clk);
    #2 CpuRst_n = 1'b1;

    // cold load, store hit, merged readback, dirty conflict, hit on new line
    do_req(1, 0, 32'h100, 0, 4'b0000, 0);
    check("cold_rdata", bus.RdData, 32'h0000_0011);
    do_req(0, 1, 32'h104, 32'hAABB_CCDD, 4'b0011, 0);
    do_req(1, 0, 32'h104, 0, 4'b0000, 0);
    check("store_merge", bus.RdData, 32'h0000_CCDD);
    do_req(1, 0, 32'h180, 0, 4'b0000, 0);
    do_req(1, 0, 32'h18C, 0, 4'b0000, 0);

    // slow memory, then back-to-back hits
    do_req(1, 0, 32'h100, 0, 4'b0000, 3);
    do_req(1, 0, 32'h100, 0, 4'b0000, 0);
    check("b2b_rdata0", bus.RdData, 32'h0000_0011);
    do_req(1, 0, 32'h10C, 0, 4'b0000, 0);
    check("b2b_rdata3", bus.RdData, 32'h0000_0044);

    // request dropped one cycle into the miss still completes the fill
    log_q.delete();
    exp_q.delete();
    model_req(0, 32'h340, 0, 4'b0000, hit, dummy);
    ack_delay = 1;
    @(negedge clk);
    bus.RdReq = 1'b1;
    bus.Addr  = 32'h340;
    @(negedge clk);
    bus.RdReq = 1'b0;
    cyc = 0;
    #1;
    while ((bus.MemRdReq || bus.MemWrReq) && cyc < 400) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("drop_done", {31'b0, bus.MemRdReq | bus.MemWrReq}, 32'd0);
    check_txns("drop");
    do_req(1, 0, 32'h344, 0, 4'b0000, 0);

    // reset during second refill word abandons the transfer
    log_q.delete();
    ack_delay = 0;
    @(negedge clk);
    bus.RdReq = 1'b1;
    bus.Addr  = 32'h140;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_refill_rd",   {31'b0, bus.MemRdReq}, 32'd1);
    check("mid_refill_addr", bus.MemAddr, 32'h144);
    #1;
    CpuRst_n  = 1'b0;
    bus.RdReq = 1'b0;
    #1;
    check("rst_abort_rd",   {31'b0, bus.MemRdReq}, 32'd0);
    check("rst_abort_addr", bus.MemAddr, 32'd0);
    @(posedge clk);
    #2 CpuRst_n = 1'b1;
    model_reset();
    do_req(1, 0, 32'h140, 0, 4'b0000, 0);
    do_req(1, 0, 32'h104, 0, 4'b0000, 0);

    // random traffic over a few tags so conflicts and dirty evictions recur
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, SETS - 1) << 4) | ($urandom_range(0, LW - 1) << 2);
      case ($urandom_range(0, 3))
        0, 1:    do_req(1, 0, a, 0, 4'b0000, $urandom_range(0, 3));
        2:       do_req(0, 1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        default: do_req(1, 1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      endcase
    end
    go_idle();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter SETS, 8, number of direct-mapped lines (power of two).
REQ-002 The block SHALL have parameter LINE_WORDS, 4, 32-bit words per line (power of two).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port CpuRst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port RdReq  input  1  MEM-stage load request.
REQ-006 The block SHALL have port WrReq  input  1  MEM-stage store request.
REQ-007 The block SHALL have port Addr  input  32  byte address of the request.
REQ-008 The block SHALL have port WrData  input  32  store data.
REQ-009 The block SHALL have port ByteEn  input  4  store byte enables.
REQ-010 The block SHALL have port RdData  output  32  load data, valid while RdReq=1 and DCacheMiss=0.
REQ-011 The block SHALL have port DCacheMiss  output  1  pipeline stall request to the hazard logic.
REQ-012 The block SHALL have port MemRdReq  output  1  word read request to main memory.
REQ-013 The block SHALL have port MemWrReq  output  1  word write request to main memory.
REQ-014 The block SHALL have port MemAddr  output  32  word-aligned memory address.
REQ-015 The block SHALL have port MemWrData  output  32  write-back data.
REQ-016 The block SHALL have port MemRdData  input  32  refill data, sampled on MemAck.
REQ-017 The block SHALL have port MemAck  input  1  memory completes the current word this cycle.

Function
REQ-018 Address split (defaults): byte [1:0], word [3:2], index [6:4], tag [31:7]; widths scale with parameters.
REQ-019 Per line: valid bit, dirty bit, tag, LINE_WORDS data words.
REQ-020 Hit = valid[index] and tag match and state IDLE; computed combinationally.
REQ-021 DCacheMiss = (RdReq|WrReq) and not Hit, combinational, so stall applies in the same cycle.
REQ-022 Read hit: RdData = stored word combinationally, zero latency; no state change.
REQ-023 Write hit: at the clock edge, bytes with ByteEn=1 updated, dirty[index] set; other bytes unchanged.
REQ-024 RdReq and WrReq both high is treated as a write.
REQ-025 FSM states: IDLE, WB, REFILL.
REQ-026 IDLE -> WB on request miss with victim valid and dirty; IDLE -> REFILL on miss with victim clean or invalid.
REQ-027 WB: MemWrReq=1, MemAddr = {victim tag, index, word counter, 2'b00}, MemWrData = victim word; counter increments on MemAck; on MemAck at last word -> REFILL, counter wraps to 0.
REQ-028 REFILL: MemRdReq=1, MemAddr = {request tag, index, counter, 2'b00}; MemRdData written into word counter on MemAck; on MemAck at last word set valid, clear dirty, store tag, -> IDLE, counter wraps to 0.
REQ-029 The request is serviced as a hit in the first IDLE cycle after REFILL; DCacheMiss drops that cycle; miss penalty = (WB words + LINE_WORDS) acks + 1 cycle.
REQ-030 MemRdReq and MemWrReq are never high together and are 0 in IDLE; request and address hold steady until MemAck.
REQ-031 The CPU holds RdReq/WrReq/Addr/WrData/ByteEn stable while DCacheMiss=1; a request dropped mid-miss still completes the fill.
REQ-032 MemAck while no memory request is outstanding is ignored.

Reset
REQ-033 CpuRst_n=0 SHALL immediately force state IDLE, counter 0, all valid and dirty bits 0, MemRdReq=0, MemWrReq=0, MemAddr=0, MemWrData=0.
REQ-034 Reset mid-WB or mid-REFILL SHALL abandon the transfer; data arrays need not be cleared.
REQ-035 After reset release, the first request to any address SHALL miss.

Verification
REQ-036 Cold load Addr=0x100, memory words 0x11,0x22,0x33,0x44 at 0x100..0x10C, ack every cycle -> DCacheMiss=1 for 5 cycles, 4 MemRdReq at 0x100..0x10C, then RdData=0x11.
REQ-037 Store hit Addr=0x104, WrData=0xAABBCCDD, ByteEn=0011 -> no miss; subsequent load 0x104 returns 0x0000CCDD.
REQ-038 Conflict load Addr=0x180 (same index, dirty victim) -> 4 MemWrReq at 0x100..0x10C with stored data, then 4 MemRdReq at 0x180..0x18C, then hit.
REQ-039 MemAck delayed 3 cycles per word -> MemAddr/MemRdReq held constant across wait cycles; fill completes correctly.
REQ-040 CpuRst_n pulsed low during second REFILL word -> MemRdReq=0 immediately; reload of the same address misses and refills fully.
REQ-041 Back-to-back load hits to 0x100 and 0x10C -> DCacheMiss=0 both cycles, no memory traffic.
